// File: rtl/bep_pkg.sv
// bep_pkg: definitions shared by the biphase-mark (BEP) encoder and decoder.
//   bep_state_t         - frame sequencer states
//   BEP_HALF_BIT_CYCLES - default clocks per half-bit period
//   BEP_PREAMBLE_BITS   - default count of zero-valued preamble bits
//   BEP_DATA_WIDTH      - default payload width
package bep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } bep_state_t;

    localparam int unsigned BEP_HALF_BIT_CYCLES = 8;
    localparam int unsigned BEP_PREAMBLE_BITS   = 4;
    localparam int unsigned BEP_DATA_WIDTH      = 8;

endpackage

// File: rtl/bep_half_bit_timer.sv
// bep_half_bit_timer: free-running half-bit period counter.
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   clear   - restart the half-bit period (counter to zero)
//   tick    - high in the last clock of each half-bit period
module bep_half_bit_timer
    import bep_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = BEP_HALF_BIT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(HALF_BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/bep_encoder.sv
// bep_encoder: frames a payload word as PREAMBLE_BITS zeros followed by
// DATA_WIDTH data bits (LSB first) and drives it as a biphase-mark line.
//   clock      - system clock
//   reset_n    - asynchronous active-low reset
//   data_in    - payload word, captured on handshake
//   data_valid - payload offered
//   data_ready - encoder accepts data_in this cycle
//   serial_out - registered BEP line
//   busy       - frame in progress
//   frame_done - one-cycle pulse after the last data bit
module bep_encoder
    import bep_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = BEP_HALF_BIT_CYCLES,
    parameter int unsigned PREAMBLE_BITS   = BEP_PREAMBLE_BITS,
    parameter int unsigned DATA_WIDTH      = BEP_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned MAX_BITS  = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
    localparam int unsigned BW        = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [BW-1:0] LAST_PRE  = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);

    bep_state_t state, state_next;

    logic                  tick;
    logic                  half;        // 0: first half of bit, 1: second half
    logic                  toggle_pend; // line toggles on the next edge
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  handshake;
    logic                  bit_end;
    logic                  last_pre;
    logic                  last_data;
    logic                  cur_bit;

    bep_half_bit_timer #(
        .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (handshake),
        .tick   (tick)
    );

    assign handshake = data_valid && data_ready;
    assign bit_end   = tick && half;
    assign last_pre  = (bit_cnt == LAST_PRE);
    assign last_data = (bit_cnt == LAST_DATA);
    assign cur_bit   = (state == ST_DATA) ? shreg[0] : 1'b0;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (handshake) state_next = ST_PREAMBLE;
            ST_PREAMBLE: if (bit_end && last_pre) state_next = ST_DATA;
            ST_DATA:     if (bit_end && last_data) state_next = handshake ? ST_PREAMBLE : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs: ready in IDLE and in the final clock of the last data bit
    always_comb begin
        data_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_DATA: data_ready = bit_end && last_data;
            default: ;
        endcase
    end

    // Line toggles are decided one edge ahead in toggle_pend, so the first
    // bit-start toggle lands on the edge after the handshake and every later
    // transition keeps the same one-clock offset from its half-bit boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            half        <= 1'b0;
            toggle_pend <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            serial_out  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            serial_out <= serial_out ^ toggle_pend;
            frame_done <= (state == ST_DATA) && bit_end && last_data;
            if (handshake) begin
                half        <= 1'b0;
                bit_cnt     <= '0;
                shreg       <= data_in;
                toggle_pend <= 1'b1;
            end else if (busy && tick) begin
                half <= ~half;
                if (!half) begin
                    // mid-bit transition only for a one
                    toggle_pend <= cur_bit;
                end else begin
                    // next bit start, unless the frame ends here
                    toggle_pend <= !((state == ST_DATA) && last_data);
                    if (state == ST_PREAMBLE) begin
                        bit_cnt <= last_pre ? '0 : bit_cnt + 1'b1;
                    end else begin
                        bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
                        shreg   <= shreg >> 1;
                    end
                end
            end else begin
                toggle_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bep_encoder.sv
module tb_bep_encoder;

    localparam int HB    = 4;
    localparam int PB    = 4;
    localparam int DW    = 8;
    localparam int BITP  = 2 * HB;
    localparam int FRAME = (PB + DW) * BITP;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_ready;
    logic          serial_out;
    logic          busy;
    logic          frame_done;

    bep_encoder #(
        .HALF_BIT_CYCLES(HB),
        .PREAMBLE_BITS  (PB),
        .DATA_WIDTH     (DW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .serial_out(serial_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        int            hs;
    } sb_t;

    typedef struct {
        logic [DW-1:0] data;
        int            exp_toggles;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[5];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic so_prev = 1'b0;
    bit   tog_log[0:8191];
    int   last_tog = 0;

    sb_t  mon_e;
    int   m_b, m_ph, m_bad, m_n;
    logic m_bv, m_ex;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: log line transitions per edge; on frame_done pop the oldest
    // expected frame and compare the whole toggle pattern against a model.
    always @(posedge clock) begin
        cyc++;
        #1;
        tog_log[cyc] = (serial_out !== so_prev);
        so_prev = serial_out;
        if (frame_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_frame_done_queue", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("frame_done_latency", cyc - mon_e.hs, FRAME);
                m_bad = 0;
                m_n   = 0;
                for (int k = 1; k <= FRAME; k++) begin
                    m_b  = (k - 1) / BITP;
                    m_ph = (k - 1) % BITP;
                    m_bv = (m_b < PB) ? 1'b0 : mon_e.data[m_b - PB];
                    m_ex = (m_ph == 0) || ((m_ph == HB) && m_bv);
                    if (tog_log[mon_e.hs + k] != m_ex) m_bad++;
                    m_n += int'(tog_log[mon_e.hs + k]);
                end
                check("toggle_pattern_mismatches", m_bad, 0);
                last_tog = m_n;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit hold, output int hs, output int waits);
        @(negedge clock);
        data_in    = d;
        data_valid = 1'b1;
        hs         = -1;
        waits      = 0;
        for (int i = 0; i < 300; i++) begin
            if (data_ready) begin
                hs = cyc + 1;
                break;
            end
            waits++;
            @(negedge clock);
        end
        check("handshake_seen", (hs >= 0) ? 1 : 0, 1);
        if (hs >= 0) begin
            sb_q.push_back('{d, hs});
            @(posedge clock);
        end
        if (!hold) begin
            @(negedge clock);
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("frame_completed", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int hs, hs2, waits, got, start;

        vecs[0] = '{8'h00, 12};
        vecs[1] = '{8'hFF, 20};
        vecs[2] = '{8'hA5, 16};
        vecs[3] = '{8'h3C, 16};
        vecs[4] = '{8'h01, 13};

        // reset state
        #3;
        check("rst_serial_out", serial_out, 0);
        check("rst_busy", busy, 0);
        check("rst_data_ready", data_ready, 1);
        check("rst_frame_done", frame_done, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // table-driven frames
        foreach (vecs[i]) begin
            send(vecs[i].data, 1'b0, hs, waits);
            @(negedge clock);
            check("busy_in_frame", busy, 1);
            check("ready_low_in_frame", data_ready, 0);
            wait_drain();
            check($sformatf("toggle_count_%02h", vecs[i].data), last_tog, vecs[i].exp_toggles);
            @(negedge clock);
            check("ready_after_frame", data_ready, 1);
            check("busy_after_frame", busy, 0);
        end

        // idle holds the line
        start = cyc;
        repeat (20) @(posedge clock);
        #2;
        got = 0;
        for (int k = start + 1; k <= cyc; k++) got += int'(tog_log[k]);
        check("idle_toggles", got, 0);

        // back-to-back frames with data_valid held high
        send(8'h01, 1'b1, hs, waits);
        send(8'h80, 1'b0, hs2, waits);
        check("b2b_handshake_gap", hs2 - hs, FRAME);
        check("b2b_ready_low_cycles", waits, FRAME - 1);
        check("b2b_ready_after_second_hs", data_ready, 0);
        wait_drain();
        check("b2b_toggles_second", last_tog, 13);
        got = 0;
        for (int k = hs2 - BITP + 2; k <= hs2; k++) got += int'(tog_log[k]);
        check("b2b_boundary_quiet", got, 0);
        check("b2b_last_bit_start", int'(tog_log[hs2 - BITP + 1]), 1);
        check("b2b_first_bit_start", int'(tog_log[hs2 + 1]), 1);

        // data_valid / data_in disturbance mid-frame
        send(8'h5A, 1'b0, hs, waits);
        got = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            data_valid = 1'($urandom_range(0, 1));
            data_in    = DW'($urandom_range(0, 255));
            if (data_valid && data_ready) got++;
        end
        data_valid = 1'b0;
        check("disturb_handshakes", got, 0);
        wait_drain();
        check("disturb_toggle_count", last_tog, 16);

        // reset mid-frame
        send(8'hFF, 1'b0, hs, waits);
        for (int i = 0; i < 200 && cyc < hs + 40; i++) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("abort_serial_out", serial_out, 0);
        check("abort_busy", busy, 0);
        check("abort_data_ready", data_ready, 1);
        check("abort_frame_done", frame_done, 0);
        sb_q.delete();
        repeat (3) @(negedge clock);
        data_in    = 8'h3C;
        data_valid = 1'b1;
        reset_n    = 1'b1;
        #1;
        check("ready_after_reset_release", data_ready, 1);
        hs = cyc + 1;
        sb_q.push_back('{8'h3C, hs});
        @(posedge clock);
        @(negedge clock);
        data_valid = 1'b0;
        check("busy_first_edge_after_reset", busy, 1);
        wait_drain();
        check("post_reset_toggle_count", last_tog, 16);

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
